// File: rtl/fma16_postnorm.sv
// fma16_postnorm: multi-cycle normalize/round/pack stage of the fp16 FMA.
// Takes the raw sum magnitude/exponent/sign from the add stage, finds the
// leading one, aligns, rounds per RoundMode and packs a binary16 result
// with {Overflow, Underflow, Inexact} flags. Single-entry, valid/ready on
// both sides; one operation walks IDLE -> LZC -> SHIFT -> ROUND -> DONE.
module fma16_postnorm (
  input  logic        clk,
  input  logic        reset,
  input  logic        InValid,
  output logic        InReady,
  input  logic [35:0] Sm,
  input  logic [6:0]  Se,
  input  logic        Ss,
  input  logic        Sticky,
  input  logic [1:0]  RoundMode,
  output logic        OutValid,
  input  logic        OutReady,
  output logic [15:0] Result,
  output logic [2:0]  Flags
);

  localparam logic [1:0] RM_RZ  = 2'b00;
  localparam logic [1:0] RM_RNE = 2'b01;
  localparam logic [1:0] RM_RM  = 2'b10;
  localparam logic [1:0] RM_RP  = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LZC,
    S_SHIFT,
    S_ROUND,
    S_DONE
  } state_t;

  // Index of the most significant set bit; 0 when the vector is all zero
  // (the zero case is flagged separately).
  function automatic logic [5:0] lead_one(input logic [35:0] v);
    logic [5:0] idx;
    idx = '0;
    for (int i = 0; i < 36; i++) begin
      if (v[i]) idx = 6'(i);
    end
    return idx;
  endfunction

  // Round-up decision from guard/round/sticky and the fraction LSB.
  function automatic logic round_up(input logic [1:0] rm, input logic sgn,
                                    input logic lsb, input logic g,
                                    input logic r, input logic st);
    logic inx;
    logic up;
    inx = g | r | st;
    case (rm)
      RM_RZ:   up = 1'b0;
      RM_RNE:  up = g & (r | st | lsb);
      RM_RM:   up = sgn & inx;
      default: up = ~sgn & inx;
    endcase
    return up;
  endfunction

  // Saturation value on overflow: infinity when the rounding direction
  // points away from zero for this sign, otherwise the largest finite.
  function automatic logic [15:0] overflow_value(input logic [1:0] rm,
                                                 input logic sgn);
    logic to_inf;
    to_inf = (rm == RM_RNE) | ((rm == RM_RP) & ~sgn) | ((rm == RM_RM) & sgn);
    return to_inf ? {sgn, 15'h7C00} : {sgn, 15'h7BFF};
  endfunction

  state_t state_q, state_d;
  logic   accept;

  // Captured operand
  logic        [35:0] sm_q;
  logic signed [6:0]  se_q;
  logic               ss_q;
  logic               sticky_q;
  logic        [1:0]  rm_q;

  // LZC stage results
  logic        [5:0]  p_q, p_d;
  logic               z_q, z_d;
  logic signed [7:0]  e_q, e_d;

  // SHIFT stage results (N[35] is the implicit one and is not kept)
  logic        [34:0] n_q, n_d;
  logic        [4:0]  exp_q, exp_d;
  logic               tiny_q, tiny_d;
  logic               ovf_q, ovf_d;
  logic               xst_q, xst_d;

  // Packed output
  logic [15:0] result_q, result_d;
  logic [2:0]  flags_q, flags_d;

  assign InReady  = (state_q == S_IDLE);
  assign OutValid = (state_q == S_DONE);
  assign Result   = result_q;
  assign Flags    = flags_q;
  assign accept   = (state_q == S_IDLE) & InValid;

  // Next-state logic for the operation sequencer.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (InValid) state_d = S_LZC;
      S_LZC:   state_d = S_SHIFT;
      S_SHIFT: state_d = S_ROUND;
      S_ROUND: state_d = S_DONE;
      S_DONE:  if (OutReady) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // State register; reset discards any operation in flight.
  always_ff @(posedge clk) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // ---- Stage 0: operand capture on accept ----
  // Operand registers load only on an accepted transfer.
  always_ff @(posedge clk) begin
    if (accept) begin
      sm_q     <= Sm;
      se_q     <= $signed(Se);
      ss_q     <= Ss;
      sticky_q <= Sticky;
      rm_q     <= RoundMode;
    end
  end

  // ---- Stage 1: leading-one position and unbiased-to-result exponent ----
  // E = Se + p - 22 in 8-bit signed arithmetic.
  always_comb begin
    logic signed [7:0] se_ext;
    se_ext = {se_q[6], se_q};
    p_d    = lead_one(sm_q);
    z_d    = ~|sm_q;
    e_d    = se_ext + $signed({2'b00, p_d}) - 8'sd22;
  end

  // LZC results are captured while in LZC.
  always_ff @(posedge clk) begin
    if (state_q == S_LZC) begin
      p_q <= p_d;
      z_q <= z_d;
      e_q <= e_d;
    end
  end

  // ---- Stage 2: alignment ----
  // Normal results put the leading one at bit 35; tiny results align to
  // the subnormal grid (shift 12+Se), or drop entirely into sticky when
  // that shift would be negative.
  always_comb begin
    logic signed [7:0] ts;
    ts     = {se_q[6], se_q} + 8'sd12;
    n_d    = '0;
    exp_d  = '0;
    tiny_d = 1'b0;
    xst_d  = 1'b0;
    ovf_d  = (e_q >= 8'sd31);
    if (e_q > 8'sd0) begin
      n_d   = 35'(sm_q << (6'd35 - p_q));
      exp_d = e_q[4:0];
    end else if (ts < 8'sd0) begin
      tiny_d = 1'b1;
      xst_d  = |sm_q;
    end else begin
      tiny_d = 1'b1;
      n_d    = 35'(sm_q << ts[5:0]);
    end
  end

  // Aligned significand and exponent field are captured while in SHIFT.
  always_ff @(posedge clk) begin
    if (state_q == S_SHIFT) begin
      n_q    <= n_d;
      exp_q  <= exp_d;
      tiny_q <= tiny_d;
      ovf_q  <= ovf_d;
      xst_q  <= xst_d;
    end
  end

  // ---- Stage 3: round, detect exceptions, pack ----
  // A fraction carry ripples into the exponent field by plain addition,
  // which covers both 1.11..1 -> 2.0 and max-subnormal -> min-normal.
  always_comb begin
    logic [9:0]  frac;
    logic        g, r, st, inx, up, ovf_any, unf;
    logic [14:0] packed_v;
    frac     = n_q[34:25];
    g        = n_q[24];
    r        = n_q[23];
    st       = (|n_q[22:0]) | sticky_q | xst_q;
    inx      = g | r | st;
    up       = round_up(rm_q, ss_q, frac[0], g, r, st);
    packed_v = {exp_q, frac} + {14'd0, up};
    ovf_any  = ovf_q | (packed_v[14:10] == 5'h1F);
    unf      = tiny_q & inx;
    result_d = {ss_q, packed_v};
    flags_d  = {1'b0, unf, inx};
    if (z_q & ~sticky_q) begin
      result_d = (rm_q == RM_RM) ? 16'h8000 : 16'h0000;
      flags_d  = 3'b000;
    end else if (ovf_any) begin
      result_d = overflow_value(rm_q, ss_q);
      flags_d  = 3'b101;
    end
  end

  // Output registers change only on the edge entering DONE.
  always_ff @(posedge clk) begin
    if (reset) begin
      result_q <= 16'h0000;
      flags_q  <= 3'b000;
    end else if (state_q == S_ROUND) begin
      result_q <= result_d;
      flags_q  <= flags_d;
    end
  end

endmodule

// File: tb/tb_fma16_postnorm.sv
// Directed bench for fma16_postnorm: expected results are queued when an
// operation is sent and popped when the DUT presents OutValid.
module tb_fma16_postnorm;

  logic        clk = 1'b0;
  logic        reset;
  logic        InValid;
  logic        InReady;
  logic [35:0] Sm;
  logic [6:0]  Se;
  logic        Ss;
  logic        Sticky;
  logic [1:0]  RoundMode;
  logic        OutValid;
  logic        OutReady;
  logic [15:0] Result;
  logic [2:0]  Flags;

  localparam logic [1:0] RZ = 2'b00, RNE = 2'b01, RM = 2'b10, RP = 2'b11;

  typedef struct packed {
    logic [15:0] res;
    logic [2:0]  flg;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  fma16_postnorm dut (
    .clk      (clk),
    .reset    (reset),
    .InValid  (InValid),
    .InReady  (InReady),
    .Sm       (Sm),
    .Se       (Se),
    .Ss       (Ss),
    .Sticky   (Sticky),
    .RoundMode(RoundMode),
    .OutValid (OutValid),
    .OutReady (OutReady),
    .Result   (Result),
    .Flags    (Flags)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic drive(input logic [35:0] a_sm, input logic [6:0] a_se,
                       input logic a_ss, input logic a_st, input logic [1:0] a_rm);
    Sm = a_sm; Se = a_se; Ss = a_ss; Sticky = a_st; RoundMode = a_rm;
  endtask

  // Present one operation and return just after its accept edge.
  task automatic send(input string tag, input logic [35:0] a_sm, input logic [6:0] a_se,
                      input logic a_ss, input logic a_st, input logic [1:0] a_rm);
    int w;
    w = 0;
    while (InReady !== 1'b1 && w < 20) begin
      tick();
      w++;
    end
    chk({tag, "_inready"}, InReady, 1);
    drive(a_sm, a_se, a_ss, a_st, a_rm);
    InValid = 1'b1;
    tick();
    InValid = 1'b0;
  endtask

  // Wait for OutValid (bounded), check latency and the scoreboard entry.
  task automatic recv(input string tag);
    int   lat;
    exp_t e;
    lat = 0;
    while (OutValid !== 1'b1 && lat < 20) begin
      tick();
      lat++;
    end
    chk({tag, "_lat"}, lat, 3);
    e = sb.pop_front();
    chk({tag, "_res"}, Result, e.res);
    chk({tag, "_flg"}, Flags, e.flg);
    if (OutReady) begin
      tick();
      chk({tag, "_drop"}, OutValid, 0);
    end
  endtask

  task automatic op(input string tag, input logic [35:0] a_sm, input logic [6:0] a_se,
                    input logic a_ss, input logic a_st, input logic [1:0] a_rm,
                    input logic [15:0] x_res, input logic [2:0] x_flg);
    sb.push_back('{res: x_res, flg: x_flg});
    send(tag, a_sm, a_se, a_ss, a_st, a_rm);
    recv(tag);
  endtask

  initial begin
    int spur;
    reset = 1'b1; InValid = 1'b0; OutReady = 1'b1;
    drive(36'd0, 7'd0, 1'b0, 1'b0, RNE);
    repeat (3) tick();
    chk("rst_inready", InReady, 1);
    chk("rst_outvalid", OutValid, 0);
    chk("rst_result", Result, 16'h0000);
    chk("rst_flags", Flags, 3'b000);
    reset = 1'b0;
    tick();

    op("one",      36'd1 << 22,                      7'd15, 1'b0, 1'b0, RNE, 16'h3C00, 3'b000);
    op("tie_rne",  (36'd1 << 22) | (36'd1 << 11),    7'd15, 1'b0, 1'b0, RNE, 16'h3C00, 3'b001);
    op("tie_rp",   (36'd1 << 22) | (36'd1 << 11),    7'd15, 1'b0, 1'b0, RP,  16'h3C01, 3'b001);
    op("tie_st",   (36'd1 << 22) | (36'd1 << 11),    7'd15, 1'b0, 1'b1, RNE, 16'h3C01, 3'b001);
    op("neg_rm",   (36'd1 << 22) | (36'd1 << 11),    7'd15, 1'b1, 1'b0, RM,  16'hBC01, 3'b001);
    op("ovf_rne",  36'd1 << 22,                      7'd45, 1'b0, 1'b0, RNE, 16'h7C00, 3'b101);
    op("ovf_rz",   36'd1 << 22,                      7'd45, 1'b0, 1'b0, RZ,  16'h7BFF, 3'b101);
    op("ovf_rp_n", 36'd1 << 22,                      7'd45, 1'b1, 1'b0, RP,  16'hFBFF, 3'b101);
    op("carry",    36'h7FFFFF,                       7'd15, 1'b0, 1'b0, RNE, 16'h4000, 3'b001);
    op("rnd_ovf",  36'h7FFFFF,                       7'd30, 1'b0, 1'b0, RNE, 16'h7C00, 3'b101);
    op("msb35",    36'd1 << 35,                      7'd2,  1'b0, 1'b0, RNE, 16'h3C00, 3'b000);
    op("subn",     36'd1 << 22,                      7'd0,  1'b0, 1'b0, RNE, 16'h0200, 3'b000);
    op("sub_min",  36'h7FFFFF,                       7'd0,  1'b0, 1'b0, RNE, 16'h0400, 3'b011);
    op("unf_zero", 36'd1,                            7'd0,  1'b0, 1'b0, RNE, 16'h0000, 3'b011);
    op("neg_sh",   36'd1 << 22,                      7'h6C, 1'b0, 1'b0, RP,  16'h0001, 3'b011);
    op("zero_rm",  36'd0,                            7'd0,  1'b0, 1'b0, RM,  16'h8000, 3'b000);

    // Back-pressure: hold DONE for 5 cycles while a new input is offered.
    OutReady = 1'b0;
    sb.push_back('{res: 16'h3C00, flg: 3'b000});
    send("bp", 36'd1 << 22, 7'd15, 1'b0, 1'b0, RNE);
    recv("bp");
    drive(36'd1 << 22, 7'd0, 1'b0, 1'b0, RNE);
    InValid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("bp_valid", OutValid, 1);
      chk("bp_result", Result, 16'h3C00);
      chk("bp_inready", InReady, 0);
    end
    OutReady = 1'b1;
    tick();
    chk("bp_drop", OutValid, 0);
    chk("bp_ready_again", InReady, 1);
    sb.push_back('{res: 16'h0200, flg: 3'b000});
    tick();
    InValid = 1'b0;
    recv("bp_next");

    // Reset while the operation sits in SHIFT.
    send("rst_op", 36'd1 << 22, 7'd45, 1'b0, 1'b0, RNE);
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("mid_outvalid", OutValid, 0);
    chk("mid_inready", InReady, 1);
    chk("mid_result", Result, 16'h0000);
    chk("mid_flags", Flags, 3'b000);
    spur = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (OutValid === 1'b1) spur++;
    end
    chk("mid_spurious", spur, 0);

    op("post_rst", 36'd1 << 22, 7'd15, 1'b1, 1'b0, RNE, 16'hBC00, 3'b000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
